// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: state codes, opcodes, ALU-op and mux selects.
// MC_RV32M_EN adds the MDU state used by the M-extension handshake.
package mc_ctrl_pkg;

    localparam logic [3:0] ST_FETCH  = 4'd0;
    localparam logic [3:0] ST_DECODE = 4'd1;
    localparam logic [3:0] ST_EXEC   = 4'd2;
    localparam logic [3:0] ST_MEM    = 4'd3;
    localparam logic [3:0] ST_WB     = 4'd4;
    localparam logic [3:0] ST_TRAP   = 4'd5;
`ifdef MC_RV32M_EN
    localparam logic [3:0] ST_MDU    = 4'd6;

    typedef enum logic [3:0] {
        S_FETCH  = ST_FETCH,
        S_DECODE = ST_DECODE,
        S_EXEC   = ST_EXEC,
        S_MEM    = ST_MEM,
        S_WB     = ST_WB,
        S_TRAP   = ST_TRAP,
        S_MDU    = ST_MDU
    } state_e;
`else
    typedef enum logic [3:0] {
        S_FETCH  = ST_FETCH,
        S_DECODE = ST_DECODE,
        S_EXEC   = ST_EXEC,
        S_MEM    = ST_MEM,
        S_WB     = ST_WB,
        S_TRAP   = ST_TRAP
    } state_e;
`endif

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'd0,
        ALUOP_BRANCH = 2'd1,
        ALUOP_OPIMM  = 2'd2,
        ALUOP_R      = 2'd3
    } aluop_e;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_RS1   = 2'd1;
    localparam logic [1:0] SRCA_ZERO  = 2'd2;
    localparam logic [1:0] SRCB_RS2   = 2'd0;
    localparam logic [1:0] SRCB_IMM   = 2'd1;
    localparam logic [1:0] RES_ALU    = 2'd0;
    localparam logic [1:0] RES_MEM    = 2'd1;
    localparam logic [1:0] RES_PC4    = 2'd2;
    localparam logic [1:0] RES_TARGET = 2'd3;

    function automatic logic op_legal(input logic [6:0] op);
        case (op)
            OP_R, OP_LOAD, OP_STORE, OP_IMM, OP_BRANCH,
            OP_JAL, OP_JALR, OP_AUIPC, OP_LUI: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

    function automatic aluop_e aluop_of(input logic [6:0] op);
        case (op)
            OP_R:      return ALUOP_R;
            OP_IMM:    return ALUOP_OPIMM;
            OP_BRANCH: return ALUOP_BRANCH;
            default:   return ALUOP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// Combinational ALU decode: maps the ALU-op class and instruction fields to the ALU operation.
module mc_aludec
    import mc_ctrl_pkg::*;
(
    input  aluop_e     aluop_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    output logic [2:0] alucontrol_o,
    output logic       alu_sub_o
);

    always_comb begin
        alucontrol_o = 3'b000;
        alu_sub_o    = 1'b0;
        unique case (aluop_i)
            ALUOP_ADD:    ;
            ALUOP_BRANCH: alu_sub_o = 1'b1;
            // Only SRAI carries a meaningful funct7b5 among the immediate ops
            ALUOP_OPIMM: begin
                alucontrol_o = funct3_i;
                alu_sub_o    = (funct3_i == 3'b101) && funct7b5_i;
            end
            ALUOP_R: begin
                alucontrol_o = funct3_i;
                alu_sub_o    = funct7b5_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RISC-V controller: FSM, memory-wait timeout, sticky traps and retire counter.
// MC_RV32M_EN enables the MDU handshake; funct7b0 is funct7[0], used to spot M-extension encodings.
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned RET_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             funct7b0,
    input  logic             br_taken,
    input  logic             imem_ack,
    input  logic             dmem_ack,
`ifdef MC_RV32M_EN
    input  logic             mdu_done,
    output logic             mdu_start,
`endif
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic             regwrite,
    output logic [1:0]       alusrc_a,
    output logic [1:0]       alusrc_b,
    output logic [1:0]       resultsrc,
    output logic [2:0]       alucontrol,
    output logic             alu_sub,
    output logic             illegal,
    output logic             timeout,
    output logic [RET_W-1:0] instret,
    output logic [3:0]       state_o
);

    localparam logic [15:0] CNT_LIMIT = 16'(MEM_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;
    logic [RET_W-1:0] instret_q;
    logic             retire;
    logic             is_store, is_mem, is_branch, is_mext, legal;

    assign is_store  = (op == OP_STORE);
    assign is_mem    = (op == OP_LOAD) || is_store;
    assign is_branch = (op == OP_BRANCH);
    assign is_mext   = (op == OP_R) && funct7b0 && !funct7b5;
`ifdef MC_RV32M_EN
    assign legal     = op_legal(op);
`else
    assign legal     = op_legal(op) && !is_mext;
`endif

    mc_aludec u_aludec (
        .aluop_i      (aluop_of(op)),
        .funct3_i     (funct3),
        .funct7b5_i   (funct7b5),
        .alucontrol_o (alucontrol),
        .alu_sub_o    (alu_sub)
    );

    // Outputs are gated by reset so nothing requests or writes while reset is held.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        retire    = 1'b0;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        regwrite  = 1'b0;
`ifdef MC_RV32M_EN
        mdu_start = 1'b0;
`endif
        if (!reset) begin
            unique case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        ir_write = 1'b1;
                        state_d  = S_DECODE;
                    end else if (cnt_q == CNT_LIMIT) begin
                        timeout_d = 1'b1;
                        state_d   = S_TRAP;
                    end
                end
                S_DECODE: begin
                    if (legal) begin
                        state_d = S_EXEC;
                    end else begin
                        illegal_d = 1'b1;
                        state_d   = S_TRAP;
                    end
                end
                S_EXEC: begin
                    if (is_mem) begin
                        state_d = S_MEM;
                    end else if (is_branch) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
`ifdef MC_RV32M_EN
                    end else if (is_mext) begin
                        mdu_start = 1'b1;
                        state_d   = S_MDU;
`endif
                    end else begin
                        state_d = S_WB;
                    end
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = is_store;
                    if (dmem_ack) begin
                        retire  = is_store;
                        state_d = is_store ? S_FETCH : S_WB;
                    end else if (cnt_q == CNT_LIMIT) begin
                        timeout_d = 1'b1;
                        state_d   = S_TRAP;
                    end
                end
                S_WB: begin
                    regwrite = 1'b1;
                    pc_write = 1'b1;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end
`ifdef MC_RV32M_EN
                S_MDU: begin
                    if (mdu_done) state_d = S_WB;
                end
`endif
                S_TRAP: ;
                default: state_d = S_TRAP;
            endcase
        end
    end

    // Any state change clears the wait count; only FETCH/MEM can stay put while waiting.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == S_FETCH || state_q == S_MEM) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_comb begin
        alusrc_a  = SRCA_RS1;
        alusrc_b  = SRCB_IMM;
        resultsrc = RES_ALU;
        case (op)
            OP_R:             alusrc_b = SRCB_RS2;
            OP_BRANCH: begin
                alusrc_b  = SRCB_RS2;
                resultsrc = br_taken ? RES_TARGET : RES_PC4;
            end
            OP_JAL, OP_AUIPC: alusrc_a = SRCA_PC;
            OP_LUI:           alusrc_a = SRCA_ZERO;
            default: ;
        endcase
        if (op == OP_LOAD) begin
            resultsrc = RES_MEM;
        end else if (op == OP_JAL || op == OP_JALR) begin
            resultsrc = RES_PC4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            if (retire) instret_q <= instret_q + RET_W'(1);
        end
    end

    assign illegal = illegal_q;
    assign timeout = timeout_q;
    assign instret = instret_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: expected retire records are queued by stimulus, popped on pc_write.
module tb_mc_controller;

    typedef struct packed {
        logic        rw;
        logic        sub;
        logic [2:0]  ctl;
        logic [31:0] ret;
    } exp_t;

    logic        clk;
    logic        reset, to_reset;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5, funct7b0, br_taken;
    logic        imem_ack, dmem_ack, to_iack, to_dack;
    logic        imem_req, dmem_req, dmem_we, ir_write, pc_write, regwrite;
    logic [1:0]  alusrc_a, alusrc_b, resultsrc;
    logic [2:0]  alucontrol;
    logic        alu_sub, illegal, timeout;
    logic [31:0] instret;
    logic [3:0]  state_o;
    logic        to_imem_req, to_dmem_req, to_dmem_we, to_ir_write, to_pc_write, to_regwrite;
    logic [1:0]  to_alusrc_a, to_alusrc_b, to_resultsrc;
    logic [2:0]  to_alucontrol;
    logic        to_alu_sub, to_illegal, to_timeout;
    logic [31:0] to_instret;
    logic [3:0]  to_state;
`ifdef MC_RV32M_EN
    logic        mdu_done, mdu_start, to_mdu_start;
`endif

    int   total = 0;
    int   bad   = 0;
    int   pcw_cnt = 0, rw_cnt = 0, dreq_cnt = 0;
    int   exp_ret = 0;
    exp_t sbq[$];

    mc_controller #(.MEM_TIMEOUT(255), .RET_W(32)) u_dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .funct7b0(funct7b0), .br_taken(br_taken), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
`ifdef MC_RV32M_EN
        .mdu_done(mdu_done), .mdu_start(mdu_start),
`endif
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_write(ir_write),
        .pc_write(pc_write), .regwrite(regwrite), .alusrc_a(alusrc_a), .alusrc_b(alusrc_b),
        .resultsrc(resultsrc), .alucontrol(alucontrol), .alu_sub(alu_sub), .illegal(illegal),
        .timeout(timeout), .instret(instret), .state_o(state_o)
    );

    mc_controller #(.MEM_TIMEOUT(4), .RET_W(32)) u_to (
        .clk(clk), .reset(to_reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .funct7b0(funct7b0), .br_taken(br_taken), .imem_ack(to_iack), .dmem_ack(to_dack),
`ifdef MC_RV32M_EN
        .mdu_done(mdu_done), .mdu_start(to_mdu_start),
`endif
        .imem_req(to_imem_req), .dmem_req(to_dmem_req), .dmem_we(to_dmem_we), .ir_write(to_ir_write),
        .pc_write(to_pc_write), .regwrite(to_regwrite), .alusrc_a(to_alusrc_a), .alusrc_b(to_alusrc_b),
        .resultsrc(to_resultsrc), .alucontrol(to_alucontrol), .alu_sub(to_alu_sub), .illegal(to_illegal),
        .timeout(to_timeout), .instret(to_instret), .state_o(to_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic rw, input logic sub, input logic [2:0] ctl);
        exp_t e;
        e.rw  = rw;
        e.sub = sub;
        e.ctl = ctl;
        e.ret = 32'(exp_ret);
        sbq.push_back(e);
        exp_ret++;
    endtask

    task automatic do_reset;
        reset    = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        br_taken = 1'b0;
        step(2);
        reset   = 1'b0;
        exp_ret = 0;
    endtask

    // Starts in a FETCH cycle, returns at the start of the next FETCH.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7b5,
                             input logic br, input int cycles,
                             input logic rw, input logic sub, input logic [2:0] ctl);
        op       = o;
        funct3   = f3;
        funct7b5 = f7b5;
        funct7b0 = 1'b0;
        br_taken = br;
        push_exp(rw, sub, ctl);
        imem_ack = 1'b1;
        step(1);
        imem_ack = 1'b0;
        step(cycles - 1);
    endtask

    // Monitor: every pc_write pulse retires one instruction and must match the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (pc_write) pcw_cnt++;
            if (regwrite) rw_cnt++;
            if (dmem_req) dreq_cnt++;
            if (pc_write) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_pc_write", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("sb_regwrite", {31'd0, regwrite}, {31'd0, e.rw});
                    chk("sb_alu_sub", {31'd0, alu_sub}, {31'd0, e.sub});
                    chk("sb_alucontrol", {29'd0, alucontrol}, {29'd0, e.ctl});
                    chk("sb_instret", instret, e.ret);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0, r0, d0;
        reset = 1'b1; to_reset = 1'b1;
        op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1; funct7b0 = 1'b0;
        br_taken = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b1; to_iack = 1'b0; to_dack = 1'b0;
`ifdef MC_RV32M_EN
        mdu_done = 1'b0;
`endif
        // Reset state, then three ADDIs with acks tied high
        step(2);
        @(negedge clk);
        chk("rst_state", {28'd0, state_o}, 32'd0);
        chk("rst_instret", instret, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_pc_write", {31'd0, pc_write}, 32'd0);
        step(1);
        reset = 1'b0;
        exp_ret = 0;
        p0 = pcw_cnt;
        push_exp(1'b1, 1'b0, 3'b000);
        push_exp(1'b1, 1'b0, 3'b000);
        push_exp(1'b1, 1'b0, 3'b000);
        @(negedge clk);
        chk("imem_req_after_reset", {31'd0, imem_req}, 32'd1);
        step(12);
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        @(negedge clk);
        chk("addi_instret", instret, 32'd3);
        chk("addi_pc_writes", 32'(pcw_cnt - p0), 32'd3);

        // ALU decode across classes, then BEQ not-taken and taken
        do_reset;
        r0 = rw_cnt;
        run_instr(7'b0010011, 3'b101, 1'b1, 1'b0, 4, 1'b1, 1'b1, 3'b101); // SRAI
        run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 4, 1'b1, 1'b1, 3'b000); // SUB
        run_instr(7'b0110011, 3'b101, 1'b0, 1'b0, 4, 1'b1, 1'b0, 3'b101); // SRL
        run_instr(7'b1101111, 3'b111, 1'b1, 1'b0, 4, 1'b1, 1'b0, 3'b000); // JAL
        run_instr(7'b0110111, 3'b101, 1'b1, 1'b0, 4, 1'b1, 1'b0, 3'b000); // LUI
        r0 = rw_cnt - r0;
        p0 = rw_cnt;
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 3, 1'b0, 1'b1, 3'b000); // BEQ not taken
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 3, 1'b0, 1'b1, 3'b000); // BEQ taken
        @(negedge clk);
        chk("alu_regwrites", 32'(r0), 32'd5);
        chk("beq_no_regwrite", 32'(rw_cnt - p0), 32'd0);
        chk("mix_instret", instret, 32'(exp_ret));

        // LW with dmem_ack in the sixth MEM cycle
        do_reset;
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
        push_exp(1'b1, 1'b0, 3'b000);
        d0 = dreq_cnt;
        r0 = rw_cnt;
        imem_ack = 1'b1;
        step(1);
        imem_ack = 1'b0;
        step(7);
        dmem_ack = 1'b1;
        step(1);
        dmem_ack = 1'b0;
        step(1);
        @(negedge clk);
        chk("lw_dmem_req_cycles", 32'(dreq_cnt - d0), 32'd6);
        chk("lw_regwrite_cycles", 32'(rw_cnt - r0), 32'd1);
        chk("lw_no_timeout", {31'd0, timeout}, 32'd0);
        chk("lw_state_fetch", {28'd0, state_o}, 32'd0);
        chk("lw_instret", instret, 32'd1);

        // Illegal opcode traps after DECODE and stays trapped
        do_reset;
        op = 7'b1111111;
        p0 = pcw_cnt;
        imem_ack = 1'b1;
        step(1);
        imem_ack = 1'b0;
        step(1);
        @(negedge clk);
        chk("illegal_state", {28'd0, state_o}, 32'd5);
        chk("illegal_flag", {31'd0, illegal}, 32'd1);
        imem_ack = 1'b1;
        step(6);
        @(negedge clk);
        chk("trap_held", {28'd0, state_o}, 32'd5);
        chk("trap_no_imem_req", {31'd0, imem_req}, 32'd0);
        chk("trap_no_pc_write", 32'(pcw_cnt - p0), 32'd0);
        do_reset;
        @(negedge clk);
        chk("illegal_cleared", {31'd0, illegal}, 32'd0);

        // funct7=0000001 R-type
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; funct7b0 = 1'b1;
        imem_ack = 1'b1;
`ifdef MC_RV32M_EN
        push_exp(1'b1, 1'b0, 3'b000);
        step(1);
        imem_ack = 1'b0;
        step(1);
        @(negedge clk);
        chk("mdu_start", {31'd0, mdu_start}, 32'd1);
        step(1);
        @(negedge clk);
        chk("mdu_state", {28'd0, state_o}, 32'd6);
        step(2);
        mdu_done = 1'b1;
        step(1);
        mdu_done = 1'b0;
        step(1);
        @(negedge clk);
        chk("mdu_instret", instret, 32'd1);
`else
        step(1);
        imem_ack = 1'b0;
        step(1);
        @(negedge clk);
        chk("mext_illegal", {31'd0, illegal}, 32'd1);
        chk("mext_trap", {28'd0, state_o}, 32'd5);
`endif

        // Reset while a store waits in MEM
        do_reset;
        op = 7'b0100011; funct3 = 3'b010; funct7b0 = 1'b0;
        imem_ack = 1'b1;
        step(1);
        imem_ack = 1'b0;
        step(2);
        @(negedge clk);
        chk("sw_dmem_req", {31'd0, dmem_req}, 32'd1);
        chk("sw_dmem_we", {31'd0, dmem_we}, 32'd1);
        step(1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        @(negedge clk);
        chk("sw_abort_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("sw_abort_instret", instret, 32'd0);
        chk("sw_abort_state", {28'd0, state_o}, 32'd0);
        chk("sw_abort_imem_req", {31'd0, imem_req}, 32'd1);

        // MEM_TIMEOUT=4 instance: no ack traps, ack on the 4th cycle does not
        reset = 1'b1;
        to_reset = 1'b1;
        step(2);
        to_reset = 1'b0;
        step(3);
        @(negedge clk);
        chk("to_c4_state", {28'd0, to_state}, 32'd0);
        chk("to_c4_flag", {31'd0, to_timeout}, 32'd0);
        step(1);
        @(negedge clk);
        chk("to_trap_state", {28'd0, to_state}, 32'd5);
        chk("to_trap_flag", {31'd0, to_timeout}, 32'd1);
        chk("to_trap_imem_req", {31'd0, to_imem_req}, 32'd0);
        to_reset = 1'b1;
        step(2);
        to_reset = 1'b0;
        step(3);
        to_iack = 1'b1;
        @(negedge clk);
        chk("to_ack_ir_write", {31'd0, to_ir_write}, 32'd1);
        step(1);
        to_iack = 1'b0;
        @(negedge clk);
        chk("to_ack_state", {28'd0, to_state}, 32'd1);
        chk("to_ack_no_flag", {31'd0, to_timeout}, 32'd0);

        step(2);
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
